// File: rtl/riscv_pkg.sv
// Shared state encoding, D_Memory layout helpers and byte-order helper for the
// operand loader.
package riscv_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, CLEAR, DONE} state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int MAT1_BASE      = 0;

    function automatic int mat2_base(input int m, input int n);
        return m * n * BYTES_PER_WORD;
    endfunction

    function automatic int res_base(input int m, input int n, input int n2);
        return (m * n + n * n2) * BYTES_PER_WORD;
    endfunction

    function automatic int res_bytes(input int m, input int n2);
        return m * n2 * BYTES_PER_WORD;
    endfunction

    // Big-endian: byte 0 is the most significant byte of the word.
    function automatic logic [7:0] be_byte(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

endpackage

// File: rtl/dmem_loader_if.sv
// Host word stream into the loader: valid/ready with a WIDTH-bit payload.
interface dmem_loader_if #(parameter int WIDTH = 32);
    logic             s_valid;
    logic [WIDTH-1:0] s_data;
    logic             s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/dmem_loader_word_serializer.sv
// Holds one 32-bit word and presents its bytes MSB first, one per cycle.
// The byte to emit at the coming edge is combinational; the caller registers it.
module word_serializer
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [31:0] word_i,
    output logic        ready_o,
    output logic        emit_o,
    output logic [7:0]  byte_o,
    output logic [1:0]  off_o,
    output logic        last_byte_o
);
    logic [31:0] word_q, word_d;
    logic [1:0]  idx_q, idx_d;
    logic        active_q, active_d;

    // A new word may be taken while the final byte of the current one goes out.
    assign ready_o     = !active_q || (idx_q == 2'd3);
    assign last_byte_o = emit_o && (off_o == 2'd3);

    always_comb begin
        word_d   = word_q;
        idx_d    = idx_q;
        active_d = active_q;
        emit_o   = 1'b0;
        byte_o   = 8'h00;
        off_o    = 2'd0;
        if (load_i) begin
            word_d   = word_i;
            idx_d    = 2'd0;
            active_d = 1'b1;
            emit_o   = 1'b1;
            byte_o   = be_byte(word_i, 2'd0);
        end else if (active_q && idx_q != 2'd3) begin
            idx_d  = idx_q + 2'd1;
            emit_o = 1'b1;
            off_o  = idx_d;
            byte_o = be_byte(word_q, idx_d);
        end else begin
            active_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q   <= '0;
            idx_q    <= '0;
            active_q <= 1'b0;
        end else begin
            word_q   <= word_d;
            idx_q    <= idx_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/dmem_loader.sv
// Streams operand words into D_Memory byte-by-byte (big-endian), zero-fills the
// result region, then releases the CPU from reset.
module dmem_loader
    import riscv_pkg::*;
#(
    parameter int M      = 3,
    parameter int N      = 3,
    parameter int N2     = 2,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 8
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              start,
    dmem_loader_if.slave      s_if,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_rst_n,
    output logic              load_done,
    output logic [7:0]        words_loaded
);
    localparam int          TOTAL     = M * N + N * N2;
    localparam int          RES_BASE  = res_base(M, N, N2);
    localparam int          RES_BYTES = res_bytes(M, N2);
    localparam logic [7:0]  TOTAL_W   = 8'(TOTAL);
    localparam logic [ADDR_W-1:0] RES_BASE_A = ADDR_W'(RES_BASE);
    localparam logic [ADDR_W-1:0] RES_LAST   = ADDR_W'(RES_BYTES - 1);

    state_t            state_q, state_d;
    logic [7:0]        words_q, words_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] clr_q, clr_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              done_q, done_d;

    logic              ser_ready, ser_emit, ser_last, xfer;
    logic [7:0]        ser_byte;
    logic [1:0]        ser_off;
    logic [ADDR_W-1:0] word_addr;

    assign s_if.s_ready = (state_q == LOAD) && ser_ready && (words_q < TOTAL_W);
    assign xfer         = s_if.s_valid && s_if.s_ready;
    assign word_addr    = ADDR_W'({words_q, 2'b00});

    word_serializer u_ser (
        .clk         (CLOCK_50),
        .rst_n       (reset_n),
        .load_i      (xfer),
        .word_i      (s_if.s_data[WIDTH-1:WIDTH-32]),
        .ready_o     (ser_ready),
        .emit_o      (ser_emit),
        .byte_o      (ser_byte),
        .off_o       (ser_off),
        .last_byte_o (ser_last)
    );

    always_comb begin
        state_d = state_q;
        words_d = words_q;
        base_d  = base_q;
        clr_d   = clr_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD;
                    words_d = 8'd0;
                end
            end
            LOAD: begin
                if (xfer) begin
                    words_d = words_q + 8'd1;
                    base_d  = word_addr;
                end
                if (ser_emit) begin
                    we_d    = 1'b1;
                    wdata_d = ser_byte;
                    addr_d  = (xfer ? word_addr : base_q) | ADDR_W'(ser_off);
                end
                // words_q already counts the final word by the time its last byte leaves
                if (ser_last && words_q == TOTAL_W) begin
                    state_d = CLEAR;
                    clr_d   = '0;
                end
            end
            CLEAR: begin
                we_d    = 1'b1;
                wdata_d = 8'h00;
                addr_d  = RES_BASE_A + clr_q;
                clr_d   = clr_q + ADDR_W'(1);
                if (clr_q == RES_LAST) state_d = DONE;
            end
        endcase
        // Asserted one cycle after entering DONE so the last clear byte lands first.
        done_d = (state_q == DONE) && (state_d == DONE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q <= IDLE;
            words_q <= '0;
            base_q  <= '0;
            clr_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            words_q <= words_d;
            base_q  <= base_d;
            clr_q   <= clr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign cpu_rst_n    = done_q;
    assign load_done    = done_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_dmem_loader.sv
// Bench for dmem_loader: write scoreboard, D_Memory model and a table of full loads.
module tb_dmem_loader;
    localparam int TOTAL     = 15;
    localparam int RES_BASE  = 60;
    localparam int RES_BYTES = 24;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        int          mode;      // 0: s_valid always high, 1: valid 1,0,0 repeating
        bit          spam;      // pulse start during LOAD/CLEAR
        logic [31:0] fill;      // 0: word w carries w+1, else this constant
        int          exp_done;  // expected cycle of first load_done, -1 = not checked
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       mem_we, cpu_rst_n, load_done;
    logic [7:0] mem_addr, mem_wdata, words_loaded;

    always #5 clk = ~clk;

    dmem_loader_if #(.WIDTH(32)) sif ();

    dmem_loader #(.M(3), .N(3), .N2(2), .WIDTH(32), .ADDR_W(8)) dut (
        .CLOCK_50     (clk),
        .reset_n      (reset_n),
        .start        (start),
        .s_if         (sif),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_rst_n    (cpu_rst_n),
        .load_done    (load_done),
        .words_loaded (words_loaded)
    );

    wr_t        sb[$];
    logic [7:0] dmem [256];
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_word(input int w, input logic [31:0] wd);
        wr_t e;
        for (int b = 0; b < 4; b++) begin
            e.addr = 8'(4 * w + b);
            e.data = 8'(wd >> (24 - 8 * b));
            sb.push_back(e);
        end
    endtask

    task automatic push_clear();
        wr_t e;
        for (int i = 0; i < RES_BYTES; i++) begin
            e.addr = 8'(RES_BASE + i);
            e.data = 8'h00;
            sb.push_back(e);
        end
    endtask

    task automatic monitor_step();
        wr_t e;
        if (mem_we === 1'b1) begin
            dmem[mem_addr] = mem_wdata;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %0h, expected no write", mem_addr, mem_wdata);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e.addr));
                check("wr_data", 32'(mem_wdata), 32'(e.data));
            end
        end
    endtask

    task automatic run_load(input vec_t v);
        int          w;
        int          done_at;
        logic [31:0] wd;
        logic [31:0] rb;
        w = 0;
        done_at = -1;
        for (int i = 0; i < 256; i++) dmem[i] = 8'hAA;
        @(negedge clk);
        start = 1'b1;
        sif.s_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("start_load_done", 32'(load_done), 32'd0);
        check("start_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("start_words", 32'(words_loaded), 32'd0);
        for (int cyc = 0; cyc < 400 && done_at < 0; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (load_done === 1'b1) begin
                done_at = cyc;
            end else begin
                start = v.spam && cyc < 80 && (cyc % 7 == 3);
                sif.s_valid = (v.mode == 0) || (cyc % 3 == 0);
                wd = (v.fill == 32'd0) ? 32'(w + 1) : v.fill;
                sif.s_data = wd;
                #1;
                if (sif.s_valid && sif.s_ready) begin
                    push_word(w, wd);
                    if (w == TOTAL - 1) push_clear();
                    w++;
                end
            end
        end
        sif.s_valid = 1'b0;
        start = 1'b0;
        if (done_at < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no load_done, expected within 400 cycles");
        end else if (v.exp_done >= 0) begin
            check("done_cycle", 32'(done_at), 32'(v.exp_done));
        end
        check("done_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        check("done_mem_we", 32'(mem_we), 32'd0);
        check("done_words", 32'(words_loaded), 32'(TOTAL));
        check("words_accepted", 32'(w), 32'(TOTAL));
        check("sb_drained", 32'(sb.size()), 32'd0);
        for (int i = 0; i < TOTAL; i++) begin
            rb = {dmem[4*i], dmem[4*i+1], dmem[4*i+2], dmem[4*i+3]};
            check("readback_operand", rb, (v.fill == 32'd0) ? 32'(i + 1) : v.fill);
        end
        for (int i = 0; i < RES_BYTES / 4; i++) begin
            rb = {dmem[RES_BASE+4*i], dmem[RES_BASE+4*i+1], dmem[RES_BASE+4*i+2], dmem[RES_BASE+4*i+3]};
            check("readback_result", rb, 32'd0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int   w;
        bit   found;

        vecs[0] = '{mode: 0, spam: 1'b0, fill: 32'd0,        exp_done: 85};
        vecs[1] = '{mode: 1, spam: 1'b0, fill: 32'd0,        exp_done: -1};
        vecs[2] = '{mode: 0, spam: 1'b1, fill: 32'd0,        exp_done: 85};
        vecs[3] = '{mode: 0, spam: 1'b0, fill: 32'hFFFFFFFF, exp_done: 85};

        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_s_ready", 32'(sif.s_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        reset_n = 1'b1;

        // Single word, then stall with no valid data
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sif.s_valid = 1'b1;
        sif.s_data  = 32'h12345678;
        #1;
        check("sw_ready_first", 32'(sif.s_ready), 32'd1);
        push_word(0, 32'h12345678);
        @(negedge clk);
        sif.s_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("sw_byte3_data", 32'(mem_wdata), 32'h78);
        check("sw_byte3_ready", 32'(sif.s_ready), 32'd1);
        @(negedge clk);
        check("sw_stall_we", 32'(mem_we), 32'd0);
        check("sw_words", 32'(words_loaded), 32'd1);

        // Four more words, then reset during word index 4 byte 2
        w = 1;
        for (int c = 0; c < 40 && w < 5; c++) begin
            sif.s_valid = 1'b1;
            sif.s_data  = 32'hA0B0C000 + 32'(w);
            #1;
            if (sif.s_ready) begin
                push_word(w, sif.s_data);
                w++;
            end
            @(negedge clk);
        end
        sif.s_valid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (mem_we === 1'b1 && mem_addr == 8'd18) found = 1'b1;
            else @(negedge clk);
        end
        check("mid_reset_reached", 32'(found), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        sb.delete();
        check("mid_reset_we", 32'(mem_we), 32'd0);
        check("mid_reset_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("mid_reset_words", 32'(words_loaded), 32'd0);
        check("mid_reset_load_done", 32'(load_done), 32'd0);
        check("mid_reset_s_ready", 32'(sif.s_ready), 32'd0);

        // Full loads: from IDLE, then each reloading from DONE
        for (int i = 0; i < 4; i++) run_load(vecs[i]);

        repeat (3) @(negedge clk);
        check("final_idle_we", 32'(mem_we), 32'd0);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
